// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using double-dabble, one bit per clock.
// Operand is accepted over in_valid/in_ready; the result is held on out_valid until out_ready.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             bin,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [$clog2(DIGITS+1)-1:0]  sig_digits,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned SigW = $clog2(DIGITS + 1);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  // ceil(WIDTH * log10(2)) in integer arithmetic
  localparam int unsigned MinDigits = (WIDTH * 30103 + 99999) / 100000;

  if (WIDTH < 4) begin : gen_bad_width
    $error("bin_to_bcd_seq: WIDTH must be at least 4");
  end
  if (DIGITS < MinDigits) begin : gen_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small to hold a WIDTH-bit value");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [BcdW-1:0]  scratch_q;
  logic [CntW-1:0]  cnt_q;

  logic [BcdW-1:0]  corr;
  logic [BcdW-1:0]  scratch_d;
  logic [SigW-1:0]  sig_d;

  // All digits are corrected from their pre-step values, then the whole chain shifts left.
  always_comb begin
    corr = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        corr[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
    scratch_d = (corr << 1) | BcdW'(bin_q[WIDTH-1]);
  end

  always_comb begin
    sig_d = SigW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_d[4*k +: 4] != 4'd0) begin
        sig_d = SigW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd        <= '0;
      sig_digits <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            bin_q     <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          scratch_q <= scratch_d;
          bin_q     <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            bcd        <= scratch_d;
            sig_digits <= sig_d;
            out_valid  <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: the driver queues expected results on accept and
// an independent monitor checks every drained result and its latency.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bin;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] bcd;
  logic [3:0]  sig_digits;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [43:0] exp_q[$];
  int          acc_q[$];

  bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .bin        (bin),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bcd        (bcd),
    .sig_digits (sig_digits),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: latency on each out_valid rise, value on each drain.
  initial begin
    logic        ov_prev;
    logic [43:0] e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) begin
          if (acc_q.size() == 0) chk("latency_no_accept", 64'(cyc), 64'hFFFF);
          else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd32);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", {20'd0, bcd, sig_digits}, 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("bcd", 64'(bcd), 64'(e[43:4]));
            chk("sig_digits", 64'(sig_digits), 64'(e[3:0]));
          end
        end
        ov_prev = out_valid;
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [39:0] eb, input logic [3:0] es,
                      output int acc);
    bool_wait: begin
      in_valid = 1'b1;
      bin      = v;
      acc      = -1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = cyc + 1;
          break;
        end
      end
      if (acc < 0) begin
        chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        disable bool_wait;
      end
      exp_q.push_back({eb, es});
      acc_q.push_back(acc);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 300), 64'd1);
    #1;
  endtask

  initial begin
    int a1, a2, n;
    rst = 1'b1; in_valid = 1'b0; bin = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_sig", 64'(sig_digits), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    send(32'd0,          40'h0,          4'd1,  a1);
    send(32'hFFFF_FFFF,  40'h4294967295, 4'd10, a1);
    send(32'd1234567890, 40'h1234567890, 4'd10, a1);
    send(32'd1000,       40'h0000001000, 4'd4,  a1);
    drain_all();

    // Backpressure: result must hold while out_ready is low, and 7 must wait.
    out_ready = 1'b0;
    send(32'd59595959, 40'h0059595959, 4'd8, a1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("bp_done_timeout", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    bin      = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_bcd", 64'(bcd), 64'h0059595959);
      chk("bp_sig", 64'(sig_digits), 64'd8);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'd7, 40'h7, 4'd1, a1);
    drain_all();

    // Reset during step 16 of a conversion.
    send(32'd65535, 40'h65535, 4'd5, a1);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_bcd", 64'(bcd), 64'd0);
    chk("mid_rst_sig", 64'(sig_digits), 64'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send(32'd9, 40'h9, 4'd1, a1);
    drain_all();

    // Back-to-back with out_ready high.
    send(32'd99,  40'h99,  4'd2, a1);
    send(32'd100, 40'h100, 4'd3, a2);
    chk("b2b_spacing", 64'(a2 - a1), 64'd34);
    drain_all();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
